// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the two-requester I2C byte arbiter: FSM encoding and
// default timeout sizing.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam int ISSUE_TIMEOUT_DEFAULT = 1023;
    localparam int TO_W_DEFAULT          = 10;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of the requester handshakes and the i2c_master request/busy pair.
// The slave modport is the arbiter; the master modport is its environment.
interface i2c_bus_arbiter_if;

    logic       i_valid0;
    logic [6:0] i_addr0;
    logic [7:0] i_data0;
    logic       i_RW0;
    logic       o_busy0;
    logic       o_done0;

    logic       i_valid1;
    logic [6:0] i_addr1;
    logic [7:0] i_data1;
    logic       i_RW1;
    logic       o_busy1;
    logic       o_done1;

    logic       o_valid;
    logic [6:0] o_addr;
    logic [7:0] o_data;
    logic       o_RW;
    logic       i_busy;
    logic       o_err;
    logic       o_owner;

    modport slave (
        input  i_valid0, i_addr0, i_data0, i_RW0,
        input  i_valid1, i_addr1, i_data1, i_RW1,
        input  i_busy,
        output o_busy0, o_done0, o_busy1, o_done1,
        output o_valid, o_addr, o_data, o_RW, o_err, o_owner
    );

    modport master (
        output i_valid0, i_addr0, i_data0, i_RW0,
        output i_valid1, i_addr1, i_data1, i_RW1,
        output i_busy,
        input  o_busy0, o_done0, o_busy1, o_done1,
        input  o_valid, o_addr, o_data, o_RW, o_err, o_owner
    );

endinterface

// File: rtl/i2c_bus_arbiter_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-high reset; shared by
// the arbiter, keypad and DS1302 paths.
module sync_2ff (
    input  logic clk,
    input  logic reset_p,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make the two stages a real shift; blocking
    // ones would collapse them into a single flop.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master between two byte requesters;
// one byte transaction per grant, with an issue timeout on the master handshake.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEFAULT,
    parameter int TO_W          = TO_W_DEFAULT   // 2**TO_W must exceed ISSUE_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_p,
    i2c_bus_arbiter_if.slave   bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ISSUE_TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            rw_q, rw_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            valid_q, busy_q;
    logic            done0_q, done1_q, err_q;
    logic            done_d, err_d;
    logic            grant_sel;
    logic            busy_s;

    // The master runs on a divided clock, so its busy is resynchronized first.
    sync_2ff u_busy_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .d_i     (bus.i_busy),
        .q_o     (busy_s)
    );

    // NOTE: every variable gets its hold/default value before the case so no
    // path through the block leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        grant_sel = rr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid0 || bus.i_valid1) begin
                    // Contested grants follow the pointer; otherwise the lone requester wins.
                    grant_sel = (bus.i_valid0 && bus.i_valid1) ? rr_q : bus.i_valid1;
                    owner_d   = grant_sel;
                    rr_d      = ~grant_sel;
                    addr_d    = grant_sel ? bus.i_addr1 : bus.i_addr0;
                    data_d    = grant_sel ? bus.i_data1 : bus.i_data0;
                    rw_d      = grant_sel ? bus.i_RW1   : bus.i_RW0;
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (busy_s) begin
                    state_d = ST_ACTIVE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!busy_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == ST_ISSUE);
            busy_q  <= (state_d != ST_IDLE);
            done0_q <= done_d & ~owner_q;
            done1_q <= done_d &  owner_q;
            err_q   <= err_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_data  = data_q;
    assign bus.o_RW    = rw_q;
    assign bus.o_owner = owner_q;
    assign bus.o_err   = err_q;
    assign bus.o_busy0 = busy_q;
    assign bus.o_busy1 = busy_q;
    assign bus.o_done0 = done0_q;
    assign bus.o_done1 = done1_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: one instance at the default timeout,
// a second with a 16-cycle timeout for the abort path.
module tb_i2c_bus_arbiter;

    logic clk = 1'b0;
    logic reset_p;
    int   total = 0;
    int   bad   = 0;
    int   d0_cnt = 0;
    int   d1_cnt = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter_if bus ();
    i2c_bus_arbiter_if bus_t ();

    i2c_bus_arbiter dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    i2c_bus_arbiter #(.ISSUE_TIMEOUT(16), .TO_W(5)) dut_t (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus_t)
    );

    always @(negedge clk) begin
        if (bus.o_done0) d0_cnt++;
        if (bus.o_done1) d1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.o_valid && cyc < 50) begin
            step(1);
            cyc++;
        end
        if (!bus.o_valid) cyc = -1;
    endtask

    // Master model: raise busy `delay` cycles after entry, hold `len` cycles,
    // report when o_valid dropped and when a done pulse appeared.
    task automatic master_txn(input int delay, input int len, output int drop_lat, output int done_lat);
        step(delay);
        bus.i_busy = 1'b1;
        drop_lat = 0;
        while (bus.o_valid && drop_lat < 20) begin
            step(1);
            drop_lat++;
        end
        if (len > drop_lat) step(len - drop_lat);
        bus.i_busy = 1'b0;
        done_lat = 0;
        while (!(bus.o_done0 || bus.o_done1) && done_lat < 20) begin
            step(1);
            done_lat++;
        end
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        {bus.i_valid0, bus.i_addr0, bus.i_data0, bus.i_RW0} = '0;
        {bus.i_valid1, bus.i_addr1, bus.i_data1, bus.i_RW1} = '0;
        bus.i_busy = 1'b0;
        {bus_t.i_valid0, bus_t.i_addr0, bus_t.i_data0, bus_t.i_RW0} = '0;
        {bus_t.i_valid1, bus_t.i_addr1, bus_t.i_data1, bus_t.i_RW1} = '0;
        bus_t.i_busy = 1'b0;
        step(2);
        total++;
        if ({bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_done0, bus.o_done1, bus.o_err, bus.o_owner, bus.o_RW} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000", {bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_done0, bus.o_done1, bus.o_err, bus.o_owner, bus.o_RW});
        end
        total++;
        if ({bus.o_addr, bus.o_data} !== 15'h0) begin
            bad++;
            $display("FAIL reset_addr_data: got %h/%h want 00/00", bus.o_addr, bus.o_data);
        end
        total++;
        if ({bus_t.o_valid, bus_t.o_busy0, bus_t.o_done0, bus_t.o_err} !== 4'h0) begin
            bad++;
            $display("FAIL reset_ctrl_t: got %b want 0000", {bus_t.o_valid, bus_t.o_busy0, bus_t.o_done0, bus_t.o_err});
        end
        reset_p = 1'b0;
        step(2);
        total++;
        if (bus.o_busy0 !== 1'b0 || bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy0=%b valid=%b want 0 0", bus.o_busy0, bus.o_valid);
        end
    endtask

    task automatic test_single;
        int s0, s1, drop, dl;
        s0 = d0_cnt;
        s1 = d1_cnt;
        bus.i_valid0 = 1'b1; bus.i_addr0 = 7'h27; bus.i_data0 = 8'h3C; bus.i_RW0 = 1'b0;
        step(1);
        // Valid drops right after the grant edge and the inputs change; capture must hold.
        bus.i_valid0 = 1'b0; bus.i_addr0 = 7'h55; bus.i_data0 = 8'hAA;
        total++;
        if ({bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_owner, bus.o_RW} !== 5'b11100) begin
            bad++;
            $display("FAIL single_grant: valid/busy0/busy1/owner/rw=%b want 11100", {bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_owner, bus.o_RW});
        end
        total++;
        if (bus.o_addr !== 7'h27 || bus.o_data !== 8'h3C) begin
            bad++;
            $display("FAIL single_capture: got %h/%h want 27/3c", bus.o_addr, bus.o_data);
        end
        master_txn(300, 2000, drop, dl);
        total++;
        if (drop < 2 || drop > 3) begin
            bad++;
            $display("FAIL single_valid_drop: got %0d clk want 2..3", drop);
        end
        total++;
        if (dl !== 3 || bus.o_done0 !== 1'b1) begin
            bad++;
            $display("FAIL single_done_lat: got %0d clk done0=%b want 3 1", dl, bus.o_done0);
        end
        total++;
        if (bus.o_addr !== 7'h27 || bus.o_data !== 8'h3C) begin
            bad++;
            $display("FAIL single_hold: got %h/%h want 27/3c", bus.o_addr, bus.o_data);
        end
        step(3);
        total++;
        if (d0_cnt - s0 !== 1 || d1_cnt - s1 !== 0 || bus.o_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL single_pulses: done0=%0d done1=%0d busy0=%b want 1 0 0", d0_cnt - s0, d1_cnt - s1, bus.o_busy0);
        end
    endtask

    task automatic test_simultaneous;
        logic [6:0] ea [2];
        logic [7:0] ed [2];
        int w, drop, dl;
        reset_p = 1'b1;
        ea[0] = 7'h10; ed[0] = 8'hA0;
        ea[1] = 7'h51; ed[1] = 8'hB1;
        bus.i_valid0 = 1'b1; bus.i_addr0 = ea[0]; bus.i_data0 = ed[0]; bus.i_RW0 = 1'b0;
        bus.i_valid1 = 1'b1; bus.i_addr1 = ea[1]; bus.i_data1 = ed[1]; bus.i_RW1 = 1'b1;
        step(1);
        reset_p = 1'b0;
        for (int t = 0; t < 4; t++) begin
            int eo;
            eo = t % 2;
            wait_valid(w);
            total++;
            if (w < 0) begin
                bad++;
                $display("FAIL sim_wait_valid_%0d: no o_valid within 50 clk", t);
            end
            total++;
            if (bus.o_owner !== eo[0] || bus.o_RW !== eo[0]) begin
                bad++;
                $display("FAIL sim_owner_%0d: owner=%b rw=%b want %0d %0d", t, bus.o_owner, bus.o_RW, eo, eo);
            end
            total++;
            if (bus.o_addr !== ea[eo] || bus.o_data !== ed[eo]) begin
                bad++;
                $display("FAIL sim_data_%0d: got %h/%h want %h/%h", t, bus.o_addr, bus.o_data, ea[eo], ed[eo]);
            end
            if (eo == 0) bus.i_valid0 = 1'b0; else bus.i_valid1 = 1'b0;
            master_txn(3, 6, drop, dl);
            total++;
            if ({bus.o_done1, bus.o_done0} !== ((eo == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL sim_done_%0d: done1/done0=%b%b want owner %0d", t, bus.o_done1, bus.o_done0, eo);
            end
            ed[eo] = ed[eo] + 8'h01;
            if (eo == 0) begin
                bus.i_data0 = ed[0]; bus.i_valid0 = 1'b1;
            end else begin
                bus.i_data1 = ed[1]; bus.i_valid1 = 1'b1;
            end
        end
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        step(2);
    endtask

    task automatic test_back_to_back;
        int w, drop, dl;
        bus.i_valid1 = 1'b1; bus.i_addr1 = 7'h33; bus.i_data1 = 8'hC3; bus.i_RW1 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_valid(w);
            total++;
            if (w < 0 || bus.o_owner !== 1'b1 || bus.o_data !== (8'hC3 + 8'(t))) begin
                bad++;
                $display("FAIL b2b_req1_%0d: wait=%0d owner=%b data=%h want owner 1 data %h", t, w, bus.o_owner, bus.o_data, 8'hC3 + 8'(t));
            end
            bus.i_valid1 = 1'b0;
            master_txn(2, 4, drop, dl);
            total++;
            if (bus.o_done1 !== 1'b1) begin
                bad++;
                $display("FAIL b2b_done1_%0d: got %b want 1", t, bus.o_done1);
            end
            if (t == 0) begin
                bus.i_data1 = 8'hC4; bus.i_valid1 = 1'b1;
            end else begin
                bus.i_valid0 = 1'b1; bus.i_addr0 = 7'h44; bus.i_data0 = 8'hD4; bus.i_RW0 = 1'b0;
                bus.i_valid1 = 1'b1; bus.i_data1 = 8'hC5;
            end
        end
        wait_valid(w);
        total++;
        if (w < 0 || bus.o_owner !== 1'b0 || bus.o_addr !== 7'h44) begin
            bad++;
            $display("FAIL b2b_contested: wait=%0d owner=%b addr=%h want owner 0 addr 44", w, bus.o_owner, bus.o_addr);
        end
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        master_txn(2, 4, drop, dl);
        step(2);
    endtask

    task automatic test_timeout;
        int cnt;
        bus_t.i_valid0 = 1'b1; bus_t.i_addr0 = 7'h22; bus_t.i_data0 = 8'h5A; bus_t.i_RW0 = 1'b0;
        step(1);
        bus_t.i_valid0 = 1'b0;
        cnt = 0;
        while (bus_t.o_valid && cnt < 40) begin
            cnt++;
            step(1);
        end
        total++;
        if (cnt !== 16) begin
            bad++;
            $display("FAIL to_valid_len: got %0d clk want 16", cnt);
        end
        total++;
        if ({bus_t.o_err, bus_t.o_done0, bus_t.o_done1, bus_t.o_busy0} !== 4'b1100) begin
            bad++;
            $display("FAIL to_pulses: err/done0/done1/busy0=%b want 1100", {bus_t.o_err, bus_t.o_done0, bus_t.o_done1, bus_t.o_busy0});
        end
        step(1);
        total++;
        if ({bus_t.o_err, bus_t.o_done0} !== 2'b00) begin
            bad++;
            $display("FAIL to_pulse_width: err/done0=%b want 00", {bus_t.o_err, bus_t.o_done0});
        end
        bus_t.i_valid1 = 1'b1; bus_t.i_addr1 = 7'h2B; bus_t.i_data1 = 8'h77; bus_t.i_RW1 = 1'b1;
        step(1);
        bus_t.i_valid1 = 1'b0;
        total++;
        if ({bus_t.o_valid, bus_t.o_owner, bus_t.o_RW} !== 3'b111 || bus_t.o_addr !== 7'h2B) begin
            bad++;
            $display("FAIL to_next_grant: valid/owner/rw=%b addr=%h want 111 2b", {bus_t.o_valid, bus_t.o_owner, bus_t.o_RW}, bus_t.o_addr);
        end
        bus_t.i_busy = 1'b1;
        step(4);
        total++;
        if (bus_t.o_valid !== 1'b0 || bus_t.o_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL to_next_active: valid=%b busy1=%b want 0 1", bus_t.o_valid, bus_t.o_busy1);
        end
        bus_t.i_busy = 1'b0;
        step(3);
        total++;
        if ({bus_t.o_done1, bus_t.o_err} !== 2'b10) begin
            bad++;
            $display("FAIL to_next_done: done1/err=%b want 10", {bus_t.o_done1, bus_t.o_err});
        end
        step(2);
    endtask

    task automatic test_reset_mid;
        int drop, dl;
        bus.i_valid0 = 1'b1; bus.i_addr0 = 7'h12; bus.i_data0 = 8'h34; bus.i_RW0 = 1'b0;
        step(1);
        bus.i_valid0 = 1'b0;
        bus.i_busy = 1'b1;
        step(5);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_busy0 !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_active: valid=%b busy0=%b want 0 1", bus.o_valid, bus.o_busy0);
        end
        #2 reset_p = 1'b1;
        #1;
        total++;
        if ({bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_done0, bus.o_done1, bus.o_err} !== 6'b0 || bus.o_addr !== 7'h0) begin
            bad++;
            $display("FAIL rst_mid_async: ctrl=%b addr=%h want 000000 00", {bus.o_valid, bus.o_busy0, bus.o_busy1, bus.o_done0, bus.o_done1, bus.o_err}, bus.o_addr);
        end
        bus.i_busy = 1'b0;
        step(2);
        reset_p = 1'b0;
        bus.i_valid0 = 1'b1; bus.i_addr0 = 7'h61; bus.i_data0 = 8'h16;
        bus.i_valid1 = 1'b1; bus.i_addr1 = 7'h62; bus.i_data1 = 8'h26;
        step(1);
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        total++;
        if ({bus.o_valid, bus.o_owner} !== 2'b10 || bus.o_addr !== 7'h61) begin
            bad++;
            $display("FAIL rst_mid_regrant: valid/owner=%b addr=%h want 10 61", {bus.o_valid, bus.o_owner}, bus.o_addr);
        end
        master_txn(2, 4, drop, dl);
        total++;
        if (dl !== 3 || bus.o_done0 !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_done: lat=%0d done0=%b want 3 1", dl, bus.o_done0);
        end
        step(2);
    endtask

    task automatic test_stale_busy;
        int s1, dl;
        bus.i_busy = 1'b1;
        step(3);
        bus.i_valid1 = 1'b1; bus.i_addr1 = 7'h3E; bus.i_data1 = 8'h99; bus.i_RW1 = 1'b0;
        step(1);
        bus.i_valid1 = 1'b0;
        total++;
        if ({bus.o_valid, bus.o_owner} !== 2'b11) begin
            bad++;
            $display("FAIL stale_grant: valid/owner=%b want 11", {bus.o_valid, bus.o_owner});
        end
        step(1);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL stale_to_active: valid=%b busy1=%b want 0 1", bus.o_valid, bus.o_busy1);
        end
        s1 = d1_cnt;
        bus.i_busy = 1'b0;
        dl = 0;
        while (!bus.o_done1 && dl < 20) begin
            step(1);
            dl++;
        end
        total++;
        if (dl !== 3) begin
            bad++;
            $display("FAIL stale_done_lat: got %0d clk want 3", dl);
        end
        step(2);
        total++;
        if (d1_cnt - s1 !== 1 || bus.o_busy1 !== 1'b0) begin
            bad++;
            $display("FAIL stale_done_once: pulses=%0d busy1=%b want 1 0", d1_cnt - s1, bus.o_busy1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stale_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
